chacha20_block_sched: RTL
=========================

// Module: chacha20_block_sched
// PURPOSE
//  Sequences the ChaCha20 block function for one message at a time.
//  Accepts a job (initial block counter, block count) and issues one core_start per block.
//  Presents a stable counter to the core, waits for core_done, then offers the finished
//  keystream block to the serializer/XOR stage via valid/ready.
//  Detects counter overflow, core timeout and abort.
// PARAMETERS
//  CNT_W     32    block counter width (RFC 8439 counter word)
//  NBLK_W    16    width of per-job block count
//  TIMEOUT   64    max cycles in WAIT before core_done is declared missing
// PORTS
//  clk           in   1       system clock
//  rst           in   1       reset, asynchronous, active-high
//  cfg_valid     in   1       job request
//  cfg_ready     out  1       job accepted when cfg_valid & cfg_ready
//  cfg_counter   in   CNT_W   counter value for first block of job
//  cfg_nblocks   in   NBLK_W  number of blocks in job
//  abort         in   1       synchronous job abort
//  core_start    out  1       one-cycle pulse: block function begins
//  core_counter  out  CNT_W   counter to block function; stable START..done
//  core_done     in   1       one-cycle pulse: block function matrix ready
//  ks_valid      out  1       keystream block available downstream
//  ks_ready      in   1       downstream accepts block
//  ks_last       out  1       current ks_valid block is final of job
//  busy          out  1       state != IDLE
//  blocks_done   out  NBLK_W  blocks handed off in current/last job
//  err_overflow  out  1       sticky: job rejected, counter would wrap
//  err_timeout   out  1       sticky: core_done missing
// BEHAVIOUR
//  Reset: state=IDLE.
//  Reset values: cfg_ready=1; core_start=0; core_counter=0; ks_valid=0; ks_last=0;
//   busy=0; blocks_done=0; err_*=0.
//  Reset mid-job discards everything; no further core_start.
//  FSM states: IDLE, START, WAIT, OUT, DRAIN. All outputs registered.
//  IDLE:
//   - cfg_ready=1.
//   - On accept, clear both err flags and blocks_done.
//   - nblocks==0: job accepted, nothing issued, remain IDLE.
//   - cfg_counter + nblocks - 1 > 2^CNT_W-1 (computed at CNT_W+1 bits):
//     reject, set err_overflow, remain IDLE.
//   - Otherwise load core_counter=cfg_counter and remaining=nblocks, -> START.
//  START:
//   - core_start=1 for exactly this cycle; -> WAIT.
//   - Timeout counter cleared.
//  WAIT:
//   - core_done -> OUT; ks_valid=1 the next cycle.
//   - ks_last = (remaining==1).
//   - Timeout counter reaching TIMEOUT (no core_done) -> set err_timeout, -> IDLE.
//  OUT:
//   - ks_valid held high, ks_last stable, until ks_ready.
//   - On handshake: blocks_done+1, remaining-1.
//   - If remaining was 1 -> IDLE (ks_valid=0 next cycle).
//   - Else core_counter+1, -> START.
//   - Next core_start occurs 1 cycle after handshake.
//  Latency: accept->core_start 1 cycle; core_done->ks_valid 1 cycle.
//  core_done outside WAIT/DRAIN: ignored.
//  abort (priority over all else; ignored in IDLE):
//   - START/OUT: -> IDLE next cycle; ks_valid drops without handshake.
//   - WAIT: -> DRAIN; core_start never reasserted.
//     DRAIN -> IDLE on core_done or timeout (timeout also sets err_timeout).
//  abort and ks_ready in same OUT cycle: abort wins, block not counted.
//  cfg_valid while busy: cfg_ready=0, request held by source, no effect.
//  Counter increments never wrap (guaranteed by overflow check); max counter 2^CNT_W-1 reachable.
// TESTING
//  1. cfg_counter=1, nblocks=3, ks_ready=1, core_done 10 cycles after each start
//     -> core_counter 1,2,3; three ks_valid; ks_last only on third; blocks_done=3; busy drops.
//  2. Backpressure: ks_ready low 20 cycles in OUT -> ks_valid, ks_last, core_counter stable;
//     no core_start until handshake.
//  3. cfg_counter=32'hFFFF_FFFE, nblocks=3 -> err_overflow=1, no core_start.
//     Then cfg_counter=32'hFFFF_FFFF, nblocks=1 -> accepted, one block, err cleared.
//  4. core_done withheld -> err_timeout=1 at TIMEOUT cycles after start, IDLE, cfg_ready=1.
//  5. abort in WAIT -> DRAIN; late core_done -> IDLE, ks_valid never asserted.
//     abort+ks_ready in OUT -> blocks_done unchanged.
//  6. Async rst asserted mid-WAIT -> all outputs at reset values immediately.
//     nblocks=0 job -> accepted, no core_start.

Source files
------------

// File: rtl/chacha20_block_sched_if.sv
// Job, core and keystream handshake bundle for the ChaCha20 block scheduler.
interface chacha20_block_sched_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned NBLK_W = 16
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_counter;
  logic [NBLK_W-1:0] cfg_nblocks;
  logic              abort;
  logic              core_start;
  logic [CNT_W-1:0]  core_counter;
  logic              core_done;
  logic              ks_valid;
  logic              ks_ready;
  logic              ks_last;
  logic              busy;
  logic [NBLK_W-1:0] blocks_done;
  logic              err_overflow;
  logic              err_timeout;

  // Job source, block core and downstream consumer seen as one driver.
  modport master (
    output cfg_valid, cfg_counter, cfg_nblocks, abort, core_done, ks_ready,
    input  cfg_ready, core_start, core_counter, ks_valid, ks_last, busy,
           blocks_done, err_overflow, err_timeout
  );

  modport slave (
    input  cfg_valid, cfg_counter, cfg_nblocks, abort, core_done, ks_ready,
    output cfg_ready, core_start, core_counter, ks_valid, ks_last, busy,
           blocks_done, err_overflow, err_timeout
  );
endinterface

// File: rtl/chacha20_block_sched.sv
// Issues one block-function run per keystream block of a job, hands each finished
// block downstream, and flags counter overflow, missing core_done and aborts.
module chacha20_block_sched #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned NBLK_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   rst,
  chacha20_block_sched_if.slave bus
);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CW1   = CNT_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_OUT, S_DRAIN} state_t;

  state_t            state_q;
  logic              cfg_ready_q;
  logic              core_start_q;
  logic [CNT_W-1:0]  core_counter_q;
  logic              ks_valid_q;
  logic              ks_last_q;
  logic              busy_q;
  logic [NBLK_W-1:0] blocks_done_q;
  logic              err_overflow_q;
  logic              err_timeout_q;
  logic [NBLK_W-1:0] remaining_q;
  logic [TMO_W-1:0]  tmo_q;

  logic [CNT_W:0]    last_cnt_c;
  logic              tmo_hit_c;

  // Counter of the final block, one bit wider so a wrap shows up in the MSB.
  assign last_cnt_c = CW1'(bus.cfg_counter) + CW1'(bus.cfg_nblocks) - CW1'(1);
  // tmo_q counts cycles since the core_start cycle.
  assign tmo_hit_c  = (tmo_q >= TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cfg_ready_q    <= 1'b1;
      core_start_q   <= 1'b0;
      core_counter_q <= '0;
      ks_valid_q     <= 1'b0;
      ks_last_q      <= 1'b0;
      busy_q         <= 1'b0;
      blocks_done_q  <= '0;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      remaining_q    <= '0;
      tmo_q          <= '0;
    end else begin
      core_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.cfg_valid) begin
            err_overflow_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            blocks_done_q  <= '0;
            if (bus.cfg_nblocks != '0) begin
              if (last_cnt_c[CNT_W]) begin
                err_overflow_q <= 1'b1;
              end else begin
                core_counter_q <= bus.cfg_counter;
                remaining_q    <= bus.cfg_nblocks;
                core_start_q   <= 1'b1;
                cfg_ready_q    <= 1'b0;
                busy_q         <= 1'b1;
                state_q        <= S_START;
              end
            end
          end
        end
        S_START: begin
          tmo_q <= TMO_W'(1);
          if (bus.abort) begin
            state_q     <= S_IDLE;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (bus.abort) begin
            state_q <= S_DRAIN;
          end else if (bus.core_done) begin
            ks_valid_q <= 1'b1;
            ks_last_q  <= (remaining_q == NBLK_W'(1));
            state_q    <= S_OUT;
          end else if (tmo_hit_c) begin
            err_timeout_q <= 1'b1;
            cfg_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        S_OUT: begin
          if (bus.abort) begin
            ks_valid_q  <= 1'b0;
            ks_last_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else if (bus.ks_ready) begin
            ks_valid_q    <= 1'b0;
            ks_last_q     <= 1'b0;
            blocks_done_q <= blocks_done_q + NBLK_W'(1);
            remaining_q   <= remaining_q - NBLK_W'(1);
            if (remaining_q == NBLK_W'(1)) begin
              cfg_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              core_counter_q <= core_counter_q + CNT_W'(1);
              core_start_q   <= 1'b1;
              state_q        <= S_START;
            end
          end
        end
        S_DRAIN: begin
          tmo_q <= tmo_q + TMO_W'(1);
          // Let the in-flight block finish so the core is idle before the next job.
          if (bus.core_done || tmo_hit_c) begin
            err_timeout_q <= err_timeout_q | ~bus.core_done;
            cfg_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready    = cfg_ready_q;
  assign bus.core_start   = core_start_q;
  assign bus.core_counter = core_counter_q;
  assign bus.ks_valid     = ks_valid_q;
  assign bus.ks_last      = ks_last_q;
  assign bus.busy         = busy_q;
  assign bus.blocks_done  = blocks_done_q;
  assign bus.err_overflow = err_overflow_q;
  assign bus.err_timeout  = err_timeout_q;
endmodule
